// File: rtl/params_pkg.sv
// params_pkg: shared types and constants for the miss initiator
package params_pkg;
  localparam int DEF_LINE_BYTES = 16;
  localparam int LINE_OFFSET_BITS = $clog2(DEF_LINE_BYTES);
  typedef logic [DEF_LINE_BYTES*8-1:0] line_t;
  typedef enum logic [2:0] {IDLE, WB, RD, WAIT, RESP} miss_state_e;
endpackage

// File: rtl/mem_miss_initiator.sv
// mem_miss_initiator: one-at-a-time cache miss engine issuing optional writeback, then refill read
module mem_miss_initiator
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  input  logic                    evict_dirty,
  input  logic [ADDR_WIDTH-1:0]   evict_addr,
  input  logic [LINE_BYTES*8-1:0] evict_data,
  output logic                    fill_valid,
  input  logic                    fill_ready,
  output logic [ADDR_WIDTH-1:0]   fill_addr,
  output logic [LINE_BYTES*8-1:0] fill_data,
  output logic                    fill_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic                    stray_o,
  output logic                    busy_o
);
  localparam int LW = LINE_BYTES*8;
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES-1);
  miss_state_e state, state_n;
  logic [ADDR_WIDTH-1:0] miss_q, evict_q;
  logic [LW-1:0] evict_data_q;
  logic [CW-1:0] cnt;
  logic timeout;
  always_comb begin
    state_n = state;
    timeout = cnt == CW'(TIMEOUT_CYCLES);
    case (state)
      IDLE: state_n = miss_valid ? (evict_dirty ? WB : RD) : IDLE;
      WB: state_n = mem_gnt ? RD : WB;
      RD: state_n = mem_gnt ? WAIT : RD;
      WAIT: state_n = (mem_rvalid || timeout) ? RESP : WAIT;
      RESP: state_n = fill_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    miss_ready = state == IDLE;
    busy_o = state != IDLE;
    fill_valid = state == RESP;
    fill_addr = miss_q;
    mem_req = state == WB || state == RD;
    mem_we = state == WB;
    mem_addr = state == WB ? evict_q : state == RD ? miss_q : '0;
    mem_wdata = state == WB ? evict_data_q : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      miss_q <= '0;
      evict_q <= '0;
      evict_data_q <= '0;
      cnt <= '0;
      fill_data <= '0;
      fill_err <= 1'b0;
      stray_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && miss_valid) begin
        miss_q <= miss_addr & ALIGN_MASK;
        evict_q <= evict_addr & ALIGN_MASK;
        evict_data_q <= evict_data;
      end
      if (state == RD && mem_gnt) cnt <= '0;
      else if (state == WAIT && !timeout) cnt <= cnt + CW'(1);
      // a response arriving in the timeout cycle still counts as success
      if (state == WAIT && mem_rvalid) begin
        fill_data <= mem_rdata;
        fill_err <= 1'b0;
      end else if (state == WAIT && timeout) begin
        fill_data <= '0;
        fill_err <= 1'b1;
      end
      if (mem_rvalid && state != WAIT) stray_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_miss_initiator.sv
// tb_mem_miss_initiator: table-driven and directed checks against an in-order line memory model
module tb_mem_miss_initiator;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  logic miss_valid = 0, miss_ready, evict_dirty = 0, fill_valid, fill_ready = 0, fill_err;
  logic [31:0] miss_addr = 0, evict_addr = 0, fill_addr, mem_addr;
  logic [127:0] evict_data = 0, fill_data, mem_wdata, mem_rdata = 0;
  logic mem_req, mem_we, mem_gnt, mem_rvalid = 0, stray_o, busy_o;
  logic t_miss_valid = 0, t_miss_ready, t_fill_valid, t_fill_ready = 0, t_fill_err;
  logic [31:0] t_miss_addr = 0, t_fill_addr, t_mem_addr;
  logic [127:0] t_fill_data, t_mem_wdata, t_rdata = 0;
  logic t_req, t_we, t_gnt, t_rvalid = 0, t_stray, t_busy;
  bit gnt_en = 1;
  int errors = 0, checks = 0, cyc = 0, wcnt = 0;
  logic [31:0] last_waddr = 0;
  assign mem_gnt = mem_req && gnt_en;
  assign t_gnt = t_req;

  mem_miss_initiator dut (
    .clk(clk), .rstn(rstn), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_addr(miss_addr), .evict_dirty(evict_dirty), .evict_addr(evict_addr),
    .evict_data(evict_data), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_err(fill_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stray_o(stray_o), .busy_o(busy_o));

  mem_miss_initiator #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rstn(rstn), .miss_valid(t_miss_valid), .miss_ready(t_miss_ready),
    .miss_addr(t_miss_addr), .evict_dirty(1'b0), .evict_addr(32'h0),
    .evict_data(128'h0), .fill_valid(t_fill_valid), .fill_ready(t_fill_ready),
    .fill_addr(t_fill_addr), .fill_data(t_fill_data), .fill_err(t_fill_err),
    .mem_req(t_req), .mem_we(t_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_gnt(t_gnt), .mem_rvalid(t_rvalid), .mem_rdata(t_rdata),
    .stray_o(t_stray), .busy_o(t_busy));

  // in-order memory: reads answer 10 cycles after grant, writes land 5 cycles after grant
  typedef struct {int due; logic [31:0] a; logic [127:0] d;} op_t;
  op_t rq[$], wq[$];
  logic [127:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (rstn && mem_req && mem_gnt) begin
      if (mem_we) begin
        wq.push_back('{cyc + 5, mem_addr, mem_wdata});
        wcnt++;
        last_waddr = mem_addr;
      end else rq.push_back('{cyc + 10, mem_addr, 128'h0});
    end
    cyc++;
    #1;
    while (wq.size() > 0 && wq[0].due <= cyc) begin
      mem[wq[0].a] = wq[0].d;
      void'(wq.pop_front());
    end
    mem_rvalid = 0;
    mem_rdata = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rvalid = 1;
      mem_rdata = mem.exists(rq[0].a) ? mem[rq[0].a] : 128'h0;
      void'(rq.pop_front());
    end
  end

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic accept(input logic d, input logic [31:0] m, input logic [31:0] e, input logic [127:0] ed);
    miss_valid = 1; evict_dirty = d; miss_addr = m; evict_addr = e; evict_data = ed;
    step;
    miss_valid = 0;
  endtask
  task automatic wait_fill(input int k0, output int k);
    k = k0;
    while (!fill_valid && k < 200) begin
      step;
      k++;
    end
  endtask
  task automatic handshake;
    fill_ready = 1;
    step;
    fill_ready = 0;
    chk("idle_after_fill", {miss_ready, fill_valid}, 2'b10);
  endtask

  typedef struct {
    logic dirty; logic [31:0] maddr, eaddr; logic [127:0] edata;
    logic [31:0] xaddr; logic [127:0] xdata; int xlat;
  } vec_t;
  vec_t v[5];
  localparam logic [127:0] L100 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] L300 = {16{8'h33}};
  localparam logic [127:0] LAA = {16{8'hAA}};
  localparam logic [127:0] L55 = {16{8'h55}};
  localparam logic [127:0] LXD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  initial begin
    int k, w0;
    v[0] = '{1'b0, 32'h104, 32'h0,   128'h0, 32'h100, L100, 12};
    v[1] = '{1'b1, 32'h200, 32'h200, LAA,    32'h200, LAA,  13};
    v[2] = '{1'b0, 32'h30F, 32'h0,   128'h0, 32'h300, L300, 12};
    v[3] = '{1'b1, 32'h104, 32'h40C, L55,    32'h100, L100, 13};
    v[4] = '{1'b0, 32'h404, 32'h0,   128'h0, 32'h400, L55,  12};
    mem[32'h100] = L100;
    mem[32'h300] = L300;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", {miss_ready, t_miss_ready}, 2'b11);
    chk("rst_ctl", {fill_valid, fill_err, mem_req, mem_we, stray_o, busy_o}, 6'b0);
    chk("rst_data", {fill_addr, mem_addr, fill_data ^ mem_wdata}, 0);
    rstn = 1;
    step;
    for (int i = 0; i < 5; i++) begin
      w0 = wcnt;
      accept(v[i].dirty, v[i].maddr, v[i].eaddr, v[i].edata);
      wait_fill(1, k);
      chk($sformatf("v%0d_latency", i), k, v[i].xlat);
      chk($sformatf("v%0d_addr", i), fill_addr, v[i].xaddr);
      chk($sformatf("v%0d_data", i), fill_data, v[i].xdata);
      chk($sformatf("v%0d_err", i), fill_err, 0);
      chk($sformatf("v%0d_writes", i), wcnt - w0, v[i].dirty);
      if (v[i].dirty) chk($sformatf("v%0d_waddr", i), last_waddr, v[i].eaddr & ~32'hF);
      handshake;
    end
    // consumer stalls the fill for five cycles
    accept(0, 32'h304, 0, 0);
    wait_fill(1, k);
    for (int j = 0; j < 5; j++) begin
      chk("stall_flags", {fill_valid, miss_ready, busy_o}, 3'b101);
      chk("stall_data", fill_data, L300);
      chk("stall_addr", fill_addr, 32'h300);
      step;
    end
    handshake;
    // memory withholds grant for three cycles during RD
    gnt_en = 0;
    accept(0, 32'h108, 0, 0);
    for (int j = 0; j < 3; j++) begin
      chk("gnt_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b10, 32'h100, 128'h0});
      step;
    end
    gnt_en = 1;
    wait_fill(4, k);
    chk("gnt_latency", k, 15);
    chk("gnt_data", fill_data, L100);
    handshake;
    // reset while waiting for read data
    accept(0, 32'h104, 0, 0);
    repeat (4) step;
    chk("pre_rst_busy", busy_o, 1);
    rstn = 0;
    rq.delete();
    #1;
    chk("mid_rst_ctl", {miss_ready, busy_o, mem_req, fill_valid, fill_err, stray_o}, 6'b100000);
    chk("mid_rst_data", {fill_addr, fill_data}, 0);
    #3;
    rstn = 1;
    step;
    accept(0, 32'h304, 0, 0);
    wait_fill(1, k);
    chk("post_rst_latency", k, 12);
    chk("post_rst_data", fill_data, L300);
    handshake;
    // TIMEOUT_CYCLES=8: response in the timeout cycle wins
    t_miss_valid = 1; t_miss_addr = 32'h57;
    step;
    t_miss_valid = 0;
    k = 1;
    while (k < 10) begin
      step;
      k++;
    end
    t_rvalid = 1; t_rdata = LXD;
    step;
    t_rvalid = 0;
    chk("to_edge_flags", {t_fill_valid, t_fill_err}, 2'b10);
    chk("to_edge_data", t_fill_data, LXD);
    chk("to_edge_addr", t_fill_addr, 32'h50);
    t_fill_ready = 1;
    step;
    t_fill_ready = 0;
    t_miss_valid = 1;
    step;
    t_miss_valid = 0;
    k = 1;
    while (!t_fill_valid && k < 100) begin
      step;
      k++;
    end
    chk("to_latency", k, 11);
    chk("to_err", t_fill_err, 1);
    chk("to_data", t_fill_data, 0);
    chk("to_no_stray", t_stray, 0);
    t_fill_ready = 1;
    step;
    t_fill_ready = 0;
    t_rvalid = 1;
    step;
    t_rvalid = 0;
    chk("late_stray", t_stray, 1);
    chk("main_no_stray", stray_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
